// File: rtl/serial_add_seq_if.sv
// serial_add_if: producer/consumer handshake bundle for serial_add_seq
//  master: drives in_valid, a, b, cin, out_ready; observes in_ready, out_valid, sum, busy
//  slave : the adder side of the same signals
interface serial_add_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;
    logic             busy;
    modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, busy);
    modport slave  (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, busy);
endinterface

// File: rtl/serial_add_seq.sv
// serial_add_seq: WIDTH-bit adder built by stepping one 2-bit full-adder slice, LSB slice first
//  clk, rst_n (async, active-low)
//  bus.in_valid/in_ready/a/b/cin : operand handshake
//  bus.out_valid/out_ready/sum   : result handshake, sum = a + b + cin (WIDTH+1 bits)
//  bus.busy                      : high while an add is running or waiting for handoff
module serial_add_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_seq #(parameter int WIDTH = 8) (
    input  logic         clk,
    input  logic         rst_n,
    serial_add_if.slave  bus
);
    localparam int STEPS = WIDTH / 2;
    localparam int IW = (STEPS > 1) ? $clog2(STEPS) : 1;
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    state_t           state, next;
    logic [WIDTH-1:0] opa, opb;
    logic [WIDTH:0]   acc;
    logic [IW-1:0]    idx;
    logic             carry, s0, c0, s1, c1, last;
    logic [1:0]       sa, sb;
    assign sa   = opa[2*idx +: 2];
    assign sb   = opb[2*idx +: 2];
    assign last = idx == IW'(STEPS - 1);
    serial_add_fa fa0 (.a(sa[0]), .b(sb[0]), .ci(carry), .s(s0), .co(c0));
    serial_add_fa fa1 (.a(sa[1]), .b(sb[1]), .ci(c0),    .s(s1), .co(c1));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next;
    always_comb begin
        next          = state;
        bus.in_ready  = state == IDLE;
        bus.out_valid = state == HOLD;
        bus.busy      = state != IDLE;
        bus.sum       = acc;
        next = state == IDLE ? (bus.in_valid ? RUN : IDLE) :
               state == RUN  ? (last ? HOLD : RUN) :
                               (bus.out_ready ? IDLE : HOLD);
    end
    // idx parks on the last slice instead of wrapping; a new accept rewinds it
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            idx   <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            opa   <= bus.a;
            opb   <= bus.b;
            acc   <= '0;
            carry <= bus.cin;
            idx   <= '0;
        end else if (state == RUN) begin
            acc[2*idx +: 2] <= {s1, s0};
            carry           <= c1;
            if (last) acc[WIDTH] <= c1;
            else      idx <= idx + IW'(1);
        end
endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: vector table, hand-written corner sequences and random compare against a + b + cin
module tb_serial_add_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_add_if #(.WIDTH(2))  i2 ();
    serial_add_if #(.WIDTH(8))  i8 ();
    serial_add_if #(.WIDTH(16)) i16 ();
    serial_add_seq #(.WIDTH(2))  u2  (.clk(clk), .rst_n(rst_n), .bus(i2));
    serial_add_seq #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(i8));
    serial_add_seq #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [8:0] exp;
    } vec_t;
    vec_t vecs [8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_ir(input int w);
        return w == 2 ? i2.in_ready : w == 8 ? i8.in_ready : i16.in_ready;
    endfunction

    function automatic logic get_ov(input int w);
        return w == 2 ? i2.out_valid : w == 8 ? i8.out_valid : i16.out_valid;
    endfunction

    function automatic logic [16:0] get_sum(input int w);
        return w == 2 ? {14'd0, i2.sum} : w == 8 ? {8'd0, i8.sum} : i16.sum;
    endfunction

    task automatic set_in(input int w, input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic ordy);
        if (w == 2) begin
            i2.in_valid = v; i2.a = a[1:0]; i2.b = b[1:0]; i2.cin = c; i2.out_ready = ordy;
        end else if (w == 8) begin
            i8.in_valid = v; i8.a = a[7:0]; i8.b = b[7:0]; i8.cin = c; i8.out_ready = ordy;
        end else begin
            i16.in_valid = v; i16.a = a; i16.b = b; i16.cin = c; i16.out_ready = ordy;
        end
    endtask

    // one full transaction: wait for in_ready, accept, count cycles to out_valid, hand off
    task automatic do_add(input int w, input logic [15:0] a, input logic [15:0] b, input logic c,
                          output logic [16:0] res, output int lat);
        int n = 0;
        set_in(w, 1'b1, a, b, c, 1'b0);
        while (!get_ir(w) && n < 50) begin tick; n++; end
        chk("accept_ready", {31'd0, get_ir(w)}, 32'd1);
        tick;
        set_in(w, 1'b0, a, b, c, 1'b0);
        lat = 0;
        while (!get_ov(w) && lat < 50) begin tick; lat++; end
        res = get_sum(w);
        set_in(w, 1'b0, a, b, c, 1'b1);
        tick;
        set_in(w, 1'b0, a, b, c, 1'b0);
    endtask

    function automatic logic [16:0] model(input int w, input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] m = (17'd1 << w) - 17'd1;
        return ({1'b0, a} & m) + ({1'b0, b} & m) + {16'd0, c};
    endfunction

    initial begin
        logic [16:0] res;
        int lat;
        logic [15:0] ra, rb;
        logic rc;
        vecs[0] = '{8'hFF, 8'h01, 1'b0, 9'h100};
        vecs[1] = '{8'hA5, 8'h5A, 1'b1, 9'h100};
        vecs[2] = '{8'h3C, 8'h0F, 1'b0, 9'h04B};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 9'h000};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
        vecs[5] = '{8'h01, 8'h01, 1'b0, 9'h002};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 9'h100};
        vecs[7] = '{8'h55, 8'hAA, 1'b0, 9'h0FF};
        set_in(2, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        set_in(8, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        set_in(16, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        tick; tick;
        chk("rst_in_ready", {31'd0, i8.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, i8.out_valid}, 32'd0);
        chk("rst_busy", {31'd0, i8.busy}, 32'd0);
        chk("rst_sum", {23'd0, i8.sum}, 32'd0);
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 8; i++) begin
            do_add(8, {8'd0, vecs[i].a}, {8'd0, vecs[i].b}, vecs[i].cin, res, lat);
            chk($sformatf("vec%0d_sum", i), {15'd0, res}, {23'd0, vecs[i].exp});
            chk($sformatf("vec%0d_lat", i), lat, 32'd4);
        end

        // backpressure: HOLD must keep sum and out_valid steady and refuse operands
        set_in(8, 1'b1, 16'h12, 16'h34, 1'b0, 1'b0);
        tick;
        set_in(8, 1'b0, 16'h12, 16'h34, 1'b0, 1'b0);
        tick; tick; tick; tick;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", {31'd0, i8.out_valid}, 32'd1);
            chk("bp_sum", {23'd0, i8.sum}, 32'h46);
            chk("bp_in_ready", {31'd0, i8.in_ready}, 32'd0);
            tick;
        end
        i8.out_ready = 1'b1;
        tick;
        i8.out_ready = 1'b0;
        chk("bp_release_in_ready", {31'd0, i8.in_ready}, 32'd1);
        chk("bp_release_out_valid", {31'd0, i8.out_valid}, 32'd0);
        chk("bp_release_busy", {31'd0, i8.busy}, 32'd0);

        // new operands during RUN are ignored; partial sum fills in slice by slice
        set_in(8, 1'b1, 16'h11, 16'h22, 1'b0, 1'b0);
        tick;
        chk("ovl_busy", {31'd0, i8.busy}, 32'd1);
        chk("ovl_sum0", {23'd0, i8.sum}, 32'h000);
        set_in(8, 1'b1, 16'h77, 16'h66, 1'b1, 1'b0);
        tick;
        chk("ovl_sum1", {23'd0, i8.sum}, 32'h003);
        tick; tick;
        chk("ovl_sum3", {23'd0, i8.sum}, 32'h033);
        tick;
        chk("ovl_out_valid", {31'd0, i8.out_valid}, 32'd1);
        chk("ovl_first_sum", {23'd0, i8.sum}, 32'h033);
        chk("ovl_in_ready_hold", {31'd0, i8.in_ready}, 32'd0);
        i8.out_ready = 1'b1;
        tick;
        i8.out_ready = 1'b0;
        chk("ovl_idle_in_ready", {31'd0, i8.in_ready}, 32'd1);
        tick;
        chk("ovl_second_busy", {31'd0, i8.busy}, 32'd1);
        i8.in_valid = 1'b0;
        lat = 0;
        while (!i8.out_valid && lat < 50) begin tick; lat++; end
        chk("ovl_second_lat", lat, 32'd4);
        chk("ovl_second_sum", {23'd0, i8.sum}, 32'h0DE);
        i8.out_ready = 1'b1;
        tick;
        i8.out_ready = 1'b0;

        // async reset in the middle of slice 2 aborts the add at once
        set_in(8, 1'b1, 16'hFF, 16'hFF, 1'b0, 1'b0);
        tick;
        set_in(8, 1'b0, 16'hFF, 16'hFF, 1'b0, 1'b0);
        tick; tick;
        chk("abort_pre_busy", {31'd0, i8.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", {31'd0, i8.in_ready}, 32'd1);
        chk("abort_out_valid", {31'd0, i8.out_valid}, 32'd0);
        chk("abort_busy", {31'd0, i8.busy}, 32'd0);
        chk("abort_sum", {23'd0, i8.sum}, 32'd0);
        tick;
        rst_n = 1'b1;
        tick;
        do_add(8, 16'h01, 16'h01, 1'b0, res, lat);
        chk("post_abort_sum", {15'd0, res}, 32'h002);
        chk("post_abort_lat", lat, 32'd4);

        // WIDTH=2: single-cycle RUN, exhaustive
        do_add(2, 16'd3, 16'd3, 1'b1, res, lat);
        chk("w2_max_sum", {15'd0, res}, 32'h7);
        chk("w2_max_lat", lat, 32'd1);
        for (int i = 0; i < 32; i++) begin
            ra = 16'(i & 3);
            rb = 16'((i >> 2) & 3);
            rc = i[4];
            do_add(2, ra, rb, rc, res, lat);
            chk($sformatf("w2_sum_%0d", i), {15'd0, res}, {15'd0, model(2, ra, rb, rc)});
        end

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            do_add(8, ra, rb, rc, res, lat);
            chk("rand8_sum", {15'd0, res}, {15'd0, model(8, ra, rb, rc)});
            if (lat != 4) chk("rand8_lat", lat, 32'd4);
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            do_add(16, ra, rb, rc, res, lat);
            chk("rand16_sum", {15'd0, res}, {15'd0, model(16, ra, rb, rc)});
            if (lat != 8) chk("rand16_lat", lat, 32'd8);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
